// File: rtl/adc_scan_pkg.sv
// Shared types and helpers for the ADC channel scan sequencer.
package adc_scan_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_SETTLE,
    S_START,
    S_WAIT,
    S_OUTPUT
  } state_t;

  localparam int AVG_CNT = 4;

  // Channel index width; never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_ch_pick.sv
// Next-enabled-channel picker: lowest set mask bit above prev, or the lowest
// set bit overall at the start of a scan.
module adc_ch_pick #(
  parameter int P_CH_CNT = 4,
  parameter int CW       = 2
) (
  input  logic [P_CH_CNT-1:0] mask,
  input  logic [CW-1:0]       prev,
  input  logic                scan_start,
  output logic [CW-1:0]       next,
  output logic                none
);

  // Walk downward so the last hit is the lowest qualifying channel.
  always_comb begin
    next = '0;
    none = 1'b1;
    for (int i = P_CH_CNT - 1; i >= 0; i--) begin
      if (mask[i] && (scan_start || i > int'(prev))) begin
        next = CW'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/adc_scan_seq.sv
// ADC channel scan sequencer: mux select, settle, start, capture, handshake out.
// Define ADC_SCAN_AVG_EN to average AVG_CNT conversions per channel.
module adc_scan_seq
  import adc_scan_pkg::*;
#(
  parameter int P_BIT_CNT = 8,
  parameter int P_CH_CNT  = 4,
  parameter int P_SETTLE  = 3
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic                               i_en,
  input  logic [P_CH_CNT-1:0]                i_ch_mask,
  output logic [ch_w(P_CH_CNT)-1:0]          o_mux_sel,
  output logic                               o_adc_start,
  input  logic                               i_adc_busy,
  input  logic                               i_adc_valid,
  input  logic [P_BIT_CNT-1:0]               i_adc_res,
  output logic [P_BIT_CNT-1:0]               o_res_data,
  output logic [ch_w(P_CH_CNT)-1:0]          o_res_ch,
  output logic                               o_res_valid,
  input  logic                               i_res_ready,
  output logic                               o_scan_done
);

  localparam int CW = ch_w(P_CH_CNT);

  state_t              state;
  logic [P_CH_CNT-1:0] scan_mask;
  logic [CW-1:0]       cur_ch;
  logic                scan_start;
  logic                busy_seen;
  logic [7:0]          settle_cnt;
  logic [CW-1:0]       pick_idx;
  logic                pick_none;

`ifdef ADC_SCAN_AVG_EN
  logic [P_BIT_CNT+1:0] acc;
  logic [1:0]           conv_cnt;
  logic [P_BIT_CNT+1:0] acc_sum;
  assign acc_sum = acc + (P_BIT_CNT+2)'(i_adc_res);
`endif

  adc_ch_pick #(.P_CH_CNT(P_CH_CNT), .CW(CW)) u_pick (
    .mask       (scan_mask),
    .prev       (cur_ch),
    .scan_start (scan_start),
    .next       (pick_idx),
    .none       (pick_none)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= S_IDLE;
      scan_mask   <= '0;
      cur_ch      <= '0;
      scan_start  <= 1'b0;
      busy_seen   <= 1'b0;
      settle_cnt  <= '0;
      o_mux_sel   <= '0;
      o_adc_start <= 1'b0;
      o_res_data  <= '0;
      o_res_ch    <= '0;
      o_res_valid <= 1'b0;
      o_scan_done <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
      acc         <= '0;
      conv_cnt    <= '0;
`endif
    end else begin
      o_adc_start <= 1'b0;
      o_scan_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_en && |i_ch_mask) begin
            scan_mask  <= i_ch_mask;
            scan_start <= 1'b1;
            state      <= S_SELECT;
          end
        end
        S_SELECT: begin
          o_mux_sel  <= pick_idx;
          cur_ch     <= pick_idx;
          scan_start <= 1'b0;
          settle_cnt <= 8'(P_SETTLE - 1);
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt == '0) begin
            o_adc_start <= 1'b1;
            state       <= S_START;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        S_START: begin
          busy_seen <= 1'b0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          // A valid left over from the previous conversion is ignored until
          // the ADC has acknowledged this start by going busy.
          if (i_adc_busy) begin
            busy_seen <= 1'b1;
          end else if (busy_seen && i_adc_valid) begin
`ifdef ADC_SCAN_AVG_EN
            if (conv_cnt == 2'(AVG_CNT - 1)) begin
              o_res_data  <= acc_sum[P_BIT_CNT+1:2];
              o_res_ch    <= cur_ch;
              o_res_valid <= 1'b1;
              acc         <= '0;
              conv_cnt    <= '0;
              state       <= S_OUTPUT;
            end else begin
              acc         <= acc_sum;
              conv_cnt    <= conv_cnt + 2'd1;
              o_adc_start <= 1'b1;
              state       <= S_START;
            end
`else
            o_res_data  <= i_adc_res;
            o_res_ch    <= cur_ch;
            o_res_valid <= 1'b1;
            state       <= S_OUTPUT;
`endif
          end
        end
        S_OUTPUT: begin
          // Dropping i_en ends the scan after this channel with no done pulse.
          if (i_res_ready) begin
            o_res_valid <= 1'b0;
            if (!i_en) begin
              state <= S_IDLE;
            end else if (!pick_none) begin
              state <= S_SELECT;
            end else begin
              o_scan_done <= 1'b1;
              if (|i_ch_mask) begin
                scan_mask  <= i_ch_mask;
                scan_start <= 1'b1;
                state      <= S_SELECT;
              end else begin
                state <= S_IDLE;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_seq.sv
// Scoreboard bench for adc_scan_seq with a behavioural busy/valid ADC model.
module tb_adc_scan_seq;

  localparam int SETTLE   = 3;
  localparam int BUSY_LEN = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       ready = 1'b1;
  logic [3:0] mask = 4'd0;
  logic [1:0] mux_sel, res_ch;
  logic       adc_start, res_valid, scan_done;
  logic       adc_busy, adc_valid;
  logic [7:0] adc_res, res_data;

  always #5 clk = ~clk;

  adc_scan_seq #(.P_BIT_CNT(8), .P_CH_CNT(4), .P_SETTLE(SETTLE)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_en        (en),
    .i_ch_mask   (mask),
    .o_mux_sel   (mux_sel),
    .o_adc_start (adc_start),
    .i_adc_busy  (adc_busy),
    .i_adc_valid (adc_valid),
    .i_adc_res   (adc_res),
    .o_res_data  (res_data),
    .o_res_ch    (res_ch),
    .o_res_valid (res_valid),
    .i_res_ready (ready),
    .o_scan_done (scan_done)
  );

  typedef struct packed {logic [3:0] ch; logic last;} exp_t;
  exp_t       exp_q[$];
  logic [3:0] gq[$];

  int vecs = 0, errs = 0, cyc = 0, pops = 0, starts = 0;
  int last_start = -1, rel_cyc = 0;
  bit first_after_rst = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    vecs++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input int ch, input bit last);
    exp_t e;
    e.ch = 4'(ch);
    e.last = last;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: busy rises one cycle after the start (stale valid still high
  // in between), lasts BUSY_LEN cycles, then valid with the new sample.
  logic       pend;
  int         bcnt, gen, k;
  logic [7:0] samp;
  always @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0; adc_busy <= 1'b0; adc_valid <= 1'b0; adc_res <= 8'd0;
      bcnt <= 0; k <= 0;
      gq.delete();
    end else if (adc_start) begin
      pend <= 1'b1;
`ifdef ADC_SCAN_AVG_EN
      samp <= {2'b00, mux_sel, 4'd0} + ((k == 0) ? 8'd10 : (k == 1) ? 8'd11 : (k == 2) ? 8'd12 : 8'd14);
      if (k == 3) gq.push_back(4'd11);
      k <= (k + 1) % 4;
`else
      samp <= {2'b00, mux_sel, 4'(gen)};
      gq.push_back(4'(gen));
      gen <= gen + 1;
`endif
    end else if (pend) begin
      pend <= 1'b0; adc_busy <= 1'b1; adc_valid <= 1'b0; bcnt <= BUSY_LEN - 1;
    end else if (adc_busy) begin
      if (bcnt == 0) begin
        adc_busy <= 1'b0; adc_valid <= 1'b1; adc_res <= samp;
      end else begin
        bcnt <= bcnt - 1;
      end
    end
  end

  // Monitor: pops the scoreboard on every transfer, checks done pulses,
  // stall stability and start timing.
  bit         chk_done = 1'b0, exp_done = 1'b0, held = 1'b0;
  logic [7:0] hd;
  logic [1:0] hc;
  exp_t       e;
  logic [3:0] g;
  always @(negedge clk) begin
    if (rst) begin
      chk_done = 1'b0; held = 1'b0; last_start = -1;
    end else begin
      if (chk_done) begin
        chk("scan_done", scan_done, exp_done);
        chk_done = 1'b0;
      end else if (scan_done) begin
        chk("stray_scan_done", scan_done, 0);
      end
      if (adc_start) begin
        starts++;
        chk("start_while_output", res_valid, 0);
        if (first_after_rst) begin
          chk("reset_to_first_start", (cyc - rel_cyc >= 2 + SETTLE), 1);
          first_after_rst = 1'b0;
        end
`ifndef ADC_SCAN_AVG_EN
        else if (last_start >= 0)
          chk("start_spacing", (cyc - last_start >= 1 + SETTLE + BUSY_LEN), 1);
`endif
        last_start = cyc;
      end
      if (res_valid && !ready) begin
        if (held) begin
          chk("stall_data", res_data, hd);
          chk("stall_ch", res_ch, hc);
        end else begin
          held = 1'b1; hd = res_data; hc = res_ch;
        end
      end
      if (res_valid && ready) begin
        held = 1'b0;
        pops++;
        chk("result_expected", (exp_q.size() > 0 && gq.size() > 0), 1);
        if (exp_q.size() > 0 && gq.size() > 0) begin
          e = exp_q.pop_front();
          g = gq.pop_front();
          chk("res_ch", res_ch, e.ch);
          chk("res_data", res_data, {e.ch, g});
`ifdef ADC_SCAN_AVG_EN
          chk("starts_per_ch", k, 0);
`endif
          exp_done = e.last;
          chk_done = 1'b1;
        end
      end
    end
  end

  task automatic wait_pops(input int n);
    int t = 0;
    while (pops < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("wait_pops", pops, n);
  endtask

  int snap;
  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mux_sel", mux_sel, 0);
    chk("rst_adc_start", adc_start, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_ch", res_ch, 0);
    chk("rst_scan_done", scan_done, 0);

    // Enabled with an empty mask: must stay idle
    @(posedge clk); #1 rst = 1'b0; en = 1'b1; mask = 4'd0;
    repeat (12) @(posedge clk);
    chk("empty_mask_starts", starts, 0);

    // Continuous scan of 1011, mask switched to 0100 during a ch1 conversion
    for (int s = 0; s < 3; s++) begin
      push_exp(0, 1'b0); push_exp(1, 1'b0); push_exp(3, 1'b1);
    end
    push_exp(2, 1'b1);
    #1 rel_cyc = cyc; first_after_rst = 1'b1; mask = 4'b1011;
    wait_pops(6);
    // Arm the mask change only after the third scan's ch0 result
    wait_pops(7);
    begin
      int t = 0;
      do begin @(negedge clk); t++; end while (!(adc_start && mux_sel == 2'd1) && t < 500);
      chk("ch1_start_seen", (adc_start && mux_sel == 2'd1), 1);
    end
    mask = 4'b0100;
    wait_pops(10);

    // Backpressure for 20 cycles, then drop enable: one more result, no done
    @(posedge clk); #1 ready = 1'b0; en = 1'b0;
    push_exp(2, 1'b0);
    begin
      int t = 0;
      while (!res_valid && t < 500) begin @(negedge clk); t++; end
      chk("stall_valid_seen", res_valid, 1);
    end
    repeat (20) @(posedge clk);
    #1 ready = 1'b1;
    wait_pops(11);
    snap = starts;
    repeat (40) @(posedge clk);
    chk("idle_after_en_low", starts, snap);

    // Reset while waiting on a conversion
    #1 en = 1'b1; mask = 4'b1011;
    begin
      int t = 0;
      while (!adc_start && t < 200) begin @(negedge clk); t++; end
      chk("pre_reset_start_seen", adc_start, 1);
    end
    repeat (4) @(posedge clk);
    #1 rst = 1'b1; exp_q.delete();
    @(posedge clk); @(negedge clk);
    chk("rst_wait_res_valid", res_valid, 0);
    chk("rst_wait_adc_start", adc_start, 0);
    @(posedge clk); #1 rst = 1'b0; rel_cyc = cyc; first_after_rst = 1'b1;
    push_exp(0, 1'b0); push_exp(1, 1'b0); push_exp(3, 1'b0);
    wait_pops(13);
    @(posedge clk); #1 en = 1'b0;
    wait_pops(14);
    repeat (40) @(posedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("gen_q_drained", gq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/adc_scan_seq.md
ADC_SCAN_SEQ -- requirements
Module: adc_scan_seq

Interface
REQ-001 The module SHALL have parameter P_BIT_CNT, default 8, meaning the ADC result width.
REQ-002 The module SHALL have parameter P_CH_CNT, default 4, meaning the analog mux channel count (2..16).
REQ-003 The module SHALL have parameter P_SETTLE, default 3, meaning the mux settling cycles before each start (1..255).
REQ-004 The module SHALL have i_clk  input  1  clock; all logic on its rising edge.
REQ-005 The module SHALL have i_reset  input  1  reset, synchronous, active-high.
REQ-006 The module SHALL have i_en  input  1  scan enable; level, continuous scanning while high.
REQ-007 The module SHALL have i_ch_mask  input  P_CH_CNT  enabled-channel mask, bit n = channel n.
REQ-008 The module SHALL have o_mux_sel  output  clog2(P_CH_CNT)  analog mux select.
REQ-009 The module SHALL have o_adc_start  output  1  one-cycle conversion start to the ADC.
REQ-010 The module SHALL have i_adc_busy  input  1  ADC sampling/converting.
REQ-011 The module SHALL have i_adc_valid  input  1  ADC result valid; level, stays high until the next start.
REQ-012 The module SHALL have i_adc_res  input  P_BIT_CNT  ADC result.
REQ-013 The module SHALL have o_res_data  output  P_BIT_CNT  channel result.
REQ-014 The module SHALL have o_res_ch  output  clog2(P_CH_CNT)  channel of o_res_data.
REQ-015 The module SHALL have o_res_valid / i_res_ready  output/input  1  valid/ready result handshake.
REQ-016 The module SHALL have o_scan_done  output  1  one-cycle pulse after the last enabled channel of a scan is accepted.

Function
REQ-017 The FSM SHALL use states IDLE, SELECT, SETTLE, START, WAIT, OUTPUT.
REQ-018 IDLE SHALL move to SELECT when i_en=1 and i_ch_mask!=0, latching i_ch_mask as the scan mask; the mask SHALL NOT change mid-scan.
REQ-019 SELECT SHALL pick the lowest enabled channel above the previous one in the scan (the lowest enabled at scan start), drive it on o_mux_sel, and go to SETTLE in one cycle.
REQ-020 SETTLE SHALL last exactly P_SETTLE cycles with o_mux_sel stable, then go to START.
REQ-021 START SHALL assert o_adc_start for exactly one cycle, then go to WAIT.
REQ-022 WAIT SHALL ignore i_adc_valid until i_adc_busy has been seen high after the start, then capture i_adc_res on the first cycle with i_adc_valid=1 and i_adc_busy=0.
REQ-023 OUTPUT SHALL hold o_res_valid, o_res_data, and o_res_ch stable until i_res_ready=1; the transfer occurs on the cycle with valid&&ready.
REQ-024 After a transfer, the FSM SHALL go to SELECT if enabled channels remain in the scan; otherwise it SHALL pulse o_scan_done and go to SELECT (new scan, mask re-latched) if i_en=1 and i_ch_mask!=0, else to IDLE.
REQ-025 Deasserting i_en mid-scan SHALL let the current channel finish through OUTPUT, then go to IDLE without o_scan_done.
REQ-026 With a mask of all zeros at scan start, the FSM SHALL remain in IDLE.
REQ-027 o_mux_sel SHALL hold its last value in IDLE.

Reset
REQ-028 Reset SHALL force IDLE, o_mux_sel=0, o_adc_start=0, o_res_valid=0, o_res_data=0, o_res_ch=0, o_scan_done=0, and clear the scan mask and accumulator.
REQ-029 Reset mid-conversion or mid-OUTPUT SHALL drop the pending result without any handshake; the first start after reset SHALL occur no earlier than 2+P_SETTLE cycles after release.

Configuration
REQ-030 Macro ADC_SCAN_AVG_EN defined: each channel SHALL run 4 conversions (SETTLE only before the first, START/WAIT repeated), sum into a P_BIT_CNT+2 bit accumulator, and output sum>>2, truncated.
REQ-031 Macro ADC_SCAN_AVG_EN undefined: each channel SHALL run one conversion and no accumulator SHALL exist.

Structure
REQ-032 Package adc_scan_pkg SHALL hold the state enum, the averaging count constant (4), and the channel-index width function.
REQ-033 Sub-module adc_ch_pick SHALL be combinational: given mask and previous index, it returns the next enabled index and a "none left" flag.

Verification
REQ-034 P_CH_CNT=4, mask=4'b1011, i_en held, ready=1 -> results on ch 0,1,3 in order, o_scan_done once per scan, then ch 0 again.
REQ-035 Mask change to 4'b0100 during a channel-1 conversion -> the current scan still outputs ch 3; the next scan outputs only ch 2.
REQ-036 ADC model with busy 10 cycles and stale valid=1 at start -> captured value equals the new conversion, not the stale one; start-to-start spacing ≥ 1+P_SETTLE+conversion.
REQ-037 i_res_ready=0 for 20 cycles -> o_res_valid, data, and ch stable; no o_adc_start issued; exactly one transfer when ready rises.
REQ-038 Reset asserted in WAIT -> o_res_valid never rises; IDLE next cycle; clean scan from ch 0 after release.
REQ-039 ADC_SCAN_AVG_EN defined, samples 8'd10, 11, 12, 14 -> o_res_data=8'd11, exactly 4 starts per channel.
